// File: rtl/vin_line_packer.sv
// vin_line_packer: packs 2-pixel Y8 strobes into OUT_W-bit words tagged with
// start-of-frame / end-of-line markers and buffers them in a first-word-fall-through
// FIFO feeding a valid/ready master port. A push into a full FIFO drops the rest of
// the frame and sets a sticky overflow flag.
// Optional feature macro: VIN_STATS_EN (active width/height measurement).
module vin_line_packer #(
  parameter int OUT_W      = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             v_pclk,
  input  logic             v_vsync,
  input  logic             v_hsync,
  input  logic             v_de,
  input  logic [15:0]      v_pixel,
  output logic [OUT_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             frame_done,
  output logic [11:0]      meas_width,
  output logic [11:0]      meas_height
);
  localparam int N  = OUT_W / 16;
  localparam int KW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DROP} state_t;
  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [OUT_W-1:0] data;
  } word_t;

  state_t           state_q, state_d;
  logic             vs_prev_q, vs_prev_d;
  logic             de_prev_q, de_prev_d;
  logic [KW-1:0]    k_q, k_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] stage_q, stage_d;
  logic             stage_vld_q, stage_vld_d;
  logic             sof_pend_q, sof_pend_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  word_t            mem_q [FIFO_DEPTH];

  logic  vs_rise, de_rise, de_fall, capture;
  logic  push, push_ok, drop, pop, full;
  word_t push_word, rd_word;

  // hsync carries no information the packer needs
  logic unused_hsync;
  assign unused_hsync = v_hsync;

  // Edge detection only compares strobe samples against the previous strobe sample
  assign vs_rise = v_pclk & v_vsync & ~vs_prev_q;
  assign de_rise = v_pclk & v_de & ~de_prev_q;
  assign de_fall = v_pclk & ~v_de & de_prev_q;
  // The de_rise strobe that leaves ARMED already carries the first pair of the frame
  assign capture = v_pclk & v_de & ((state_q == ACTIVE) | ((state_q == ARMED) & de_rise));

  assign pop  = m_valid & m_ready;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Capture FSM, pair packing, stage hand-off and FIFO pointer updates
  always_comb begin
    state_d      = state_q;
    vs_prev_d    = vs_prev_q;
    de_prev_d    = de_prev_q;
    k_d          = k_q;
    acc_d        = acc_q;
    stage_d      = stage_q;
    stage_vld_d  = stage_vld_q;
    sof_pend_d   = sof_pend_q;
    overflow_d   = overflow_q;
    frame_done_d = vs_rise && (state_q != IDLE);
    push         = 1'b0;
    push_word    = '0;
    drop         = 1'b0;
    push_ok      = 1'b0;

    if (v_pclk) begin
      vs_prev_d = v_vsync;
      de_prev_d = v_de;
    end

    // A staged full word leaves on the strobe after its last pair; eol tells whether
    // the line ended right there. Otherwise a line end flushes the partial word.
    if (v_pclk && stage_vld_q) begin
      push          = 1'b1;
      push_word.sof = sof_pend_q;
      push_word.eol = ~v_de;
      push_word.data = stage_q;
      stage_vld_d   = 1'b0;
    end else if (de_fall && (k_q != '0) && (state_q == ACTIVE)) begin
      push          = 1'b1;
      push_word.sof = sof_pend_q;
      push_word.eol = 1'b1;
      push_word.data = acc_q;
      acc_d         = '0;
      k_d           = '0;
    end
    if (push) sof_pend_d = 1'b0;

    // Earlier pixel goes to the low byte of its 16-bit slot
    if (capture) begin
      acc_d[{k_q, 4'b0000} +: 16] = {v_pixel[7:0], v_pixel[15:8]};
      if (k_q == KW'(N - 1)) begin
        stage_d     = acc_d;
        stage_vld_d = 1'b1;
        acc_d       = '0;
        k_d         = '0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end

    // A pop in the same cycle frees a slot, so only a push with no pop can be lost
    drop    = push && full && !pop;
    push_ok = push && !drop;

    case (state_q)
      IDLE:    if (vs_rise && enable) state_d = ARMED;
      ARMED:   if (de_rise) state_d = ACTIVE;
      default: if (vs_rise) state_d = enable ? ARMED : IDLE;
    endcase

    if (drop) begin
      stage_vld_d = 1'b0;
      k_d         = '0;
      acc_d       = '0;
      if (!vs_rise) state_d = DROP;
    end

    if ((state_d == ARMED) && (state_q != ARMED)) begin
      sof_pend_d = 1'b1;
      k_d        = '0;
      acc_d      = '0;
    end

    // Setting the overflow flag wins over a clear request in the same cycle
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Control state with synchronous reset
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      k_q          <= '0;
      stage_vld_q  <= 1'b0;
      sof_pend_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_prev_d;
      de_prev_q    <= de_prev_d;
      k_q          <= k_d;
      stage_vld_q  <= stage_vld_d;
      sof_pend_q   <= sof_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Datapath registers; their contents are qualified by k/stage_vld/pointers
  always_ff @(posedge pclk) begin
    acc_q   <= acc_d;
    stage_q <= stage_d;
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid    = (wr_ptr_q != rd_ptr_q);
  assign m_data     = m_valid ? rd_word.data : '0;
  assign m_sof      = m_valid & rd_word.sof;
  assign m_eol      = m_valid & rd_word.eol;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

`ifdef VIN_STATS_EN
  logic [11:0] pair_cnt_q, pair_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [11:0] last_pairs_q, last_pairs_d;
  logic [11:0] meas_w_q, meas_w_d;
  logic [11:0] meas_h_q, meas_h_d;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [11:0] sat_dbl(input logic [11:0] v);
    return v[11] ? 12'hFFF : {v[10:0], 1'b0};
  endfunction

  // Pair/line counters run in every state except IDLE and publish on vsync
  always_comb begin
    pair_cnt_d   = pair_cnt_q;
    line_cnt_d   = line_cnt_q;
    last_pairs_d = last_pairs_q;
    meas_w_d     = meas_w_q;
    meas_h_d     = meas_h_q;
    if (state_q != IDLE) begin
      if (v_pclk && v_de) pair_cnt_d = sat_inc(pair_cnt_q);
      if (de_fall) begin
        last_pairs_d = pair_cnt_q;
        line_cnt_d   = sat_inc(line_cnt_q);
        pair_cnt_d   = '0;
      end
      if (vs_rise) begin
        meas_w_d     = sat_dbl(last_pairs_d);
        meas_h_d     = line_cnt_d;
        pair_cnt_d   = '0;
        line_cnt_d   = '0;
        last_pairs_d = '0;
      end
    end
  end

  // Measurement registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      pair_cnt_q   <= '0;
      line_cnt_q   <= '0;
      last_pairs_q <= '0;
      meas_w_q     <= '0;
      meas_h_q     <= '0;
    end else begin
      pair_cnt_q   <= pair_cnt_d;
      line_cnt_q   <= line_cnt_d;
      last_pairs_q <= last_pairs_d;
      meas_w_q     <= meas_w_d;
      meas_h_q     <= meas_h_d;
    end
  end

  assign meas_width  = meas_w_q;
  assign meas_height = meas_h_q;
`else
  assign meas_width  = 12'd0;
  assign meas_height = 12'd0;
`endif

endmodule

// File: tb/tb_vin_line_packer.sv
// Testbench for vin_line_packer (OUT_W=64, FIFO_DEPTH=16).
module tb_vin_line_packer;
  localparam int OUT_W = 64;
  localparam int DEPTH = 16;
  localparam int N     = OUT_W / 16;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [OUT_W-1:0] data;
  } word_t;

  typedef struct {
    int          npairs;
    int          exp_words;
    logic [63:0] exp_last;
  } vec_t;

  logic             pclk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             v_pclk = 1'b0;
  logic             v_vsync = 1'b0;
  logic             v_hsync = 1'b0;
  logic             v_de = 1'b0;
  logic [15:0]      v_pixel = 16'h0;
  logic [OUT_W-1:0] m_data;
  logic             m_sof, m_eol, m_valid;
  logic             m_ready = 1'b1;
  logic             overflow;
  logic             ovf_clr = 1'b0;
  logic             frame_done;
  logic [11:0]      meas_width, meas_height;

  int    n_checks = 0;
  int    n_err    = 0;
  int    gap_mode = 0;
  bit    glitch_en = 1'b0;
  bit    rand_ready = 1'b0;
  bit    exp_sof_pend = 1'b0;
  word_t exp_q[$];
  word_t got_q[$];
  vec_t  tbl[6];

  vin_line_packer #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .v_pclk(v_pclk), .v_vsync(v_vsync),
    .v_hsync(v_hsync), .v_de(v_de), .v_pixel(v_pixel), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready), .overflow(overflow),
    .ovf_clr(ovf_clr), .frame_done(frame_done), .meas_width(meas_width),
    .meas_height(meas_height)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output collector: a word is taken when valid and ready are both high at the edge
  initial begin
    word_t w;
    forever begin
      @(negedge pclk);
      if (m_valid === 1'b1 && m_ready === 1'b1 && rst === 1'b0) begin
        w.sof = m_sof; w.eol = m_eol; w.data = m_data;
        got_q.push_back(w);
      end
    end
  end

  // Random backpressure
  initial begin
    forever begin
      @(posedge pclk); #2;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_sample(input logic vs, input logic de, input logic [15:0] px);
    int gap;
    gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gap; g++) begin
      v_pclk = 1'b0;
      if (glitch_en) begin
        v_de = 1'($urandom); v_vsync = 1'($urandom);
        v_pixel = 16'($urandom); v_hsync = 1'($urandom);
      end
      @(posedge pclk); #1;
    end
    v_pclk = 1'b1; v_vsync = vs; v_de = de; v_hsync = ~de; v_pixel = px;
    @(posedge pclk); #1;
    v_pclk = 1'b0;
  endtask

  task automatic send_vsync(input int exp_fd);
    send_sample(1'b1, 1'b0, 16'h0);
    if (exp_fd >= 0) chk("frame_done", frame_done, exp_fd);
    send_sample(1'b1, 1'b0, 16'h0);
    send_sample(1'b0, 1'b0, 16'h0);
    send_sample(1'b0, 1'b0, 16'h0);
    if (enable) exp_sof_pend = 1'b1;
  endtask

  // Drives one line and, if asked, appends the words it must produce: pairs are
  // grouped N per word in arrival order, the last word of the line is zero padded
  task automatic send_line(input int np, input bit rnd, input bit model);
    logic [15:0] px[$];
    logic [15:0] p;
    word_t       e;
    int          nw;
    for (int i = 0; i < np; i++) begin
      p = rnd ? 16'($urandom) : {8'(2 * i + 1), 8'(2 * i + 2)};
      px.push_back(p);
      send_sample(1'b0, 1'b1, p);
    end
    for (int i = 0; i < 3; i++) send_sample(1'b0, 1'b0, 16'h0);
    if (model) begin
      nw = (np + N - 1) / N;
      for (int w = 0; w < nw; w++) begin
        e.data = '0;
        for (int j = 0; j < N; j++)
          if (w * N + j < np) e.data[16 * j +: 16] = {px[w * N + j][7:0], px[w * N + j][15:8]};
        e.sof = exp_sof_pend && (w == 0);
        e.eol = (w == nw - 1);
        exp_q.push_back(e);
      end
      exp_sof_pend = 1'b0;
    end
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 600 && got_q.size() < n; i++) begin
      @(posedge pclk); #1;
    end
    repeat (20) @(posedge pclk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    wait_words(exp_q.size());
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int np, nwd, nl;
    tbl[0] = '{1, 1, 64'h0000_0000_0000_0201};
    tbl[1] = '{3, 1, 64'h0000_0605_0403_0201};
    tbl[2] = '{4, 1, 64'h0807_0605_0403_0201};
    tbl[3] = '{5, 2, 64'h0000_0000_0000_0a09};
    tbl[4] = '{8, 2, 64'h100f_0e0d_0c0b_0a09};
    tbl[5] = '{9, 3, 64'h0000_0000_0000_1211};

    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_m_data", {m_sof, m_eol, m_data}, 0);
    chk("rst_meas", {meas_width, meas_height}, 0);

    // Disabled in IDLE: nothing is captured
    send_vsync(0);
    send_line(4, 1'b0, 1'b0);
    wait_words(0);
    chk("idle_words", got_q.size(), 0);
    got_q.delete();

    // Table of line lengths, strobe every 2nd cycle with glitches in between
    enable = 1'b1; gap_mode = 1; glitch_en = 1'b1;
    send_vsync(0);
    for (int c = 0; c < 6; c++) begin
      np = tbl[c].npairs; nwd = tbl[c].exp_words;
      send_line(np, 1'b0, 1'b0);
      send_line(np, 1'b0, 1'b0);
      send_vsync(1);
      wait_words(2 * nwd);
      chk($sformatf("tbl%0d_count", c), got_q.size(), 2 * nwd);
      if (got_q.size() >= 2 * nwd) begin
        chk($sformatf("tbl%0d_sof_first", c), got_q[0].sof, 1);
        chk($sformatf("tbl%0d_eol_line1", c), got_q[nwd - 1].eol, 1);
        chk($sformatf("tbl%0d_sof_line2", c), got_q[nwd].sof, 0);
        chk($sformatf("tbl%0d_last_data", c), got_q[2 * nwd - 1].data, tbl[c].exp_last);
        chk($sformatf("tbl%0d_last_eol", c), got_q[2 * nwd - 1].eol, 1);
        if (nwd > 1) chk($sformatf("tbl%0d_mid_eol", c), got_q[0].eol, 0);
      end
`ifdef VIN_STATS_EN
      chk($sformatf("tbl%0d_meas_width", c), meas_width, 2 * np);
      chk($sformatf("tbl%0d_meas_height", c), meas_height, 2);
`else
      chk($sformatf("tbl%0d_meas_width", c), meas_width, 0);
      chk($sformatf("tbl%0d_meas_height", c), meas_height, 0);
`endif
      got_q.delete();
    end

    // Disabling mid-frame finishes the frame, then nothing more is captured
    gap_mode = 0; glitch_en = 1'b0;
    send_line(4, 1'b1, 1'b1);
    enable = 1'b0;
    send_line(4, 1'b1, 1'b1);
    send_vsync(1);
    send_line(4, 1'b1, 1'b0);
    send_vsync(0);
    send_line(3, 1'b1, 1'b0);
    compare_all("disable");
    enable = 1'b1;
    send_vsync(0);

    // Overflow: 20 words into a 16-deep FIFO with no reader
    m_ready = 1'b0;
    for (int l = 0; l < 10; l++) send_line(8, 1'b1, 1'b1);
    chk("ovf_set", overflow, 1);
    chk("ovf_m_valid", m_valid, 1);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    ovf_clr = 1'b1;
    @(posedge pclk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    send_vsync(1);
    m_ready = 1'b1;
    compare_all("ovf_held");
    send_line(4, 1'b1, 1'b1);
    send_vsync(1);
    compare_all("after_ovf");

    // Reset mid-line with 3 words waiting
    m_ready = 1'b0;
    send_line(12, 1'b1, 1'b0);
    send_sample(1'b0, 1'b1, 16'($urandom));
    send_sample(1'b0, 1'b1, 16'($urandom));
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_overflow", overflow, 0);
    chk("post_rst_data", {m_sof, m_eol, m_data}, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_sample(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) send_sample(1'b0, 1'b0, 16'h0);
    send_line(4, 1'b1, 1'b0);
    compare_all("post_rst_silent");
    send_vsync(0);
    send_line(5, 1'b1, 1'b1);
    send_vsync(1);
    compare_all("post_rst_frame");

    // Random frames, random strobe spacing with glitches, random backpressure
    gap_mode = 2; glitch_en = 1'b1; rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 13), 1'b1, 1'b1);
      send_vsync(1);
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    compare_all("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
